// File: rtl/cache_pkg.sv
// Shared types and helpers for the read-only fill cache.
package cache_pkg;

  // Controller states: accept/lookup, line fetch request, word fill, miss response.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MISS_REQ = 2'd1,
    ST_FILL     = 2'd2,
    ST_RESPOND  = 2'd3
  } state_t;

  // Width of an index into n items; never returns less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cache_way_store.sv
// One cache way: word-writable data array, per-set tag and valid bit.
// Reads are combinational on the lookup index; writes come from the fill engine.
module cache_way_store
  import cache_pkg::*;
#(
  parameter int SIZE_WORD  = 32,
  parameter int BIT_TAG    = 16,
  parameter int BIT_INDEX  = 6,
  parameter int BIT_OFFSET = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic [BIT_INDEX-1:0]  i_rd_index,
  input  logic [BIT_OFFSET-1:0] i_rd_offset,
  output logic                  o_rd_valid,
  output logic [BIT_TAG-1:0]    o_rd_tag,
  output logic [SIZE_WORD-1:0]  o_rd_data,
  input  logic                  i_wr_word,
  input  logic [BIT_INDEX-1:0]  i_wr_index,
  input  logic [BIT_OFFSET-1:0] i_wr_offset,
  input  logic [SIZE_WORD-1:0]  i_wr_data,
  input  logic                  i_line_wr,
  input  logic [BIT_TAG-1:0]    i_line_tag,
  input  logic                  i_line_valid
);

  localparam int SETS  = 1 << BIT_INDEX;
  localparam int WORDS = 1 << BIT_OFFSET;

  logic [SIZE_WORD-1:0] r_data [SETS*WORDS];
  logic [BIT_TAG-1:0]   r_tag  [SETS];
  logic [SETS-1:0]      r_valid;

  // Data word write during fill.
  // NOTE: storage arrays have no reset -- a line is only trusted through its valid bit,
  // and leaving the arrays unreset lets them map onto plain RAM.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignment for all clocked state so every register samples
    // the pre-edge values regardless of block ordering.
    if (i_wr_word) r_data[{i_wr_index, i_wr_offset}] <= i_wr_data;
  end

  // Tag write when the last word of a line lands.
  always_ff @(posedge i_clk) begin
    if (i_line_wr) r_tag[i_wr_index] <= i_line_tag;
  end

  // Valid bits: reset and flush clear every set; flush beats a same-cycle install.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) r_valid <= '0;
    else if (i_line_wr)   r_valid[i_wr_index] <= i_line_valid;
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[{i_rd_index, i_rd_offset}];

endmodule

// File: rtl/cache_ro_fill.sv
// Read-only set-associative cache with a line fill engine.
// Hits answer one cycle after accept; misses fetch the full line, install it, then answer.
module cache_ro_fill
  import cache_pkg::*;
#(
  parameter int SIZE_WORD  = 32,
  parameter int BIT_ADDR   = 24,
  parameter int BIT_INDEX  = 6,
  parameter int BIT_OFFSET = 2,
  parameter int WAY        = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [BIT_ADDR-1:0]  i_req_addr,
  output logic                 o_rsp_valid,
  output logic [SIZE_WORD-1:0] o_rsp_data,
  output logic                 o_rsp_hit,
  output logic                 o_mem_req,
  output logic [BIT_ADDR-1:0]  o_mem_addr,
  input  logic                 i_mem_ack,
  input  logic                 i_mem_valid,
  input  logic [SIZE_WORD-1:0] i_mem_data
);

  localparam int BIT_TAG = BIT_ADDR - BIT_INDEX - BIT_OFFSET;
  localparam int BIT_WAY = clog2_min1(WAY);
  localparam int SETS    = 1 << BIT_INDEX;

  state_t                r_state;
  logic [BIT_ADDR-1:0]   r_addr;
  logic [BIT_WAY-1:0]    r_victim;
  logic [BIT_OFFSET-1:0] r_cnt;
  logic                  r_cancel;
  logic [SIZE_WORD-1:0]  r_cap;
  logic [BIT_WAY-1:0]    r_rr [SETS];
  logic                  r_rsp_valid;
  logic                  r_rsp_hit;
  logic [SIZE_WORD-1:0]  r_rsp_data;
  logic                  r_mem_req;
  logic [BIT_ADDR-1:0]   r_mem_addr;

  logic [BIT_TAG-1:0]    w_req_tag;
  logic [BIT_INDEX-1:0]  w_req_index;
  logic [BIT_OFFSET-1:0] w_req_offset;
  logic [BIT_TAG-1:0]    w_fill_tag;
  logic [BIT_INDEX-1:0]  w_fill_index;
  logic [BIT_OFFSET-1:0] w_fill_offset;
  logic                  w_accept;
  logic                  w_fill_we;
  logic                  w_fill_last;
  logic                  w_line_valid;
  logic                  w_hit;
  logic [SIZE_WORD-1:0]  w_hit_data;
  logic [BIT_WAY-1:0]    w_victim;
  logic                  w_way_valid [WAY];
  logic [BIT_TAG-1:0]    w_way_tag   [WAY];
  logic [SIZE_WORD-1:0]  w_way_data  [WAY];

  assign w_req_tag     = i_req_addr[BIT_ADDR-1 -: BIT_TAG];
  assign w_req_index   = i_req_addr[BIT_OFFSET +: BIT_INDEX];
  assign w_req_offset  = i_req_addr[BIT_OFFSET-1:0];
  assign w_fill_tag    = r_addr[BIT_ADDR-1 -: BIT_TAG];
  assign w_fill_index  = r_addr[BIT_OFFSET +: BIT_INDEX];
  assign w_fill_offset = r_addr[BIT_OFFSET-1:0];

  // Requests are only taken in IDLE, and a flush in the same cycle refuses them.
  assign o_req_ready  = (r_state == ST_IDLE) && !i_flush;
  assign w_accept     = i_req_valid && o_req_ready;
  assign w_fill_we    = (r_state == ST_FILL) && i_mem_valid;
  assign w_fill_last  = w_fill_we && (r_cnt == {BIT_OFFSET{1'b1}});
  // A flush seen during the miss (latched or current) keeps the new line invalid.
  assign w_line_valid = !r_cancel && !i_flush;

  for (genvar g = 0; g < WAY; g++) begin : g_way
    cache_way_store #(
      .SIZE_WORD (SIZE_WORD),
      .BIT_TAG   (BIT_TAG),
      .BIT_INDEX (BIT_INDEX),
      .BIT_OFFSET(BIT_OFFSET)
    ) u_way (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_flush     (i_flush),
      .i_rd_index  (w_req_index),
      .i_rd_offset (w_req_offset),
      .o_rd_valid  (w_way_valid[g]),
      .o_rd_tag    (w_way_tag[g]),
      .o_rd_data   (w_way_data[g]),
      .i_wr_word   (w_fill_we && (r_victim == BIT_WAY'(g))),
      .i_wr_index  (w_fill_index),
      .i_wr_offset (r_cnt),
      .i_wr_data   (i_mem_data),
      .i_line_wr   (w_fill_last && (r_victim == BIT_WAY'(g))),
      .i_line_tag  (w_fill_tag),
      .i_line_valid(w_line_valid)
    );
  end

  // Tag compare across all ways of the addressed set.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int w = 0; w < WAY; w++) begin
      if (w_way_valid[w] && (w_way_tag[w] == w_req_tag)) begin
        w_hit      = 1'b1;
        w_hit_data = w_way_data[w];
      end
    end
  end

  // Victim: lowest-numbered invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    w_victim = r_rr[w_req_index];
    for (int w = WAY - 1; w >= 0; w--) begin
      if (!w_way_valid[w]) w_victim = BIT_WAY'(w);
    end
  end

  // Controller: lookup, line request, word fill, miss response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_victim    <= '0;
      r_cnt       <= '0;
      r_cancel    <= 1'b0;
      r_cap       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_data  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cancel <= 1'b0;
          if (w_accept) begin
            if (w_hit) begin
              r_rsp_valid <= 1'b1;
              r_rsp_hit   <= 1'b1;
              r_rsp_data  <= w_hit_data;
            end else begin
              r_addr     <= i_req_addr;
              r_victim   <= w_victim;
              r_mem_req  <= 1'b1;
              r_mem_addr <= {w_req_tag, w_req_index, {BIT_OFFSET{1'b0}}};
              r_state    <= ST_MISS_REQ;
            end
          end
        end
        ST_MISS_REQ: begin
          if (i_mem_ack) begin
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (i_mem_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == w_fill_offset) r_cap <= i_mem_data;
            if (w_fill_last) begin
              r_rr[w_fill_index] <= (r_rr[w_fill_index] == BIT_WAY'(WAY - 1)) ?
                                    '0 : r_rr[w_fill_index] + 1'b1;
              // The response is registered here so it is visible throughout RESPOND.
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= (r_cnt == w_fill_offset) ? i_mem_data : r_cap;
              r_state     <= ST_RESPOND;
            end
          end
        end
        ST_RESPOND: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
      if (i_flush && ((r_state == ST_MISS_REQ) || (r_state == ST_FILL))) r_cancel <= 1'b1;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_hit   = r_rsp_hit;
  assign o_rsp_data  = r_rsp_data;
  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_cache_ro_fill.sv
// Directed bench for cache_ro_fill with a response scoreboard.
// Memory content model: word at address a holds 0x90 + a.
module tb_cache_ro_fill;

  logic        i_clk;
  logic        i_rst;
  logic        i_flush;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [7:0]  i_req_addr;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_data;
  logic        o_rsp_hit;
  logic        o_mem_req;
  logic [7:0]  o_mem_addr;
  logic        i_mem_ack;
  logic        i_mem_valid;
  logic [31:0] i_mem_data;

  typedef struct packed {
    logic [31:0] data;
    logic        hit;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   n_compared;
  int   n_mismatched;

  cache_ro_fill #(
    .SIZE_WORD (32),
    .BIT_ADDR  (8),
    .BIT_INDEX (2),
    .BIT_OFFSET(1),
    .WAY       (2)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_flush    (i_flush),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_addr (i_req_addr),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_data (o_rsp_data),
    .o_rsp_hit  (o_rsp_hit),
    .o_mem_req  (o_mem_req),
    .o_mem_addr (o_mem_addr),
    .i_mem_ack  (i_mem_ack),
    .i_mem_valid(i_mem_valid),
    .i_mem_data (i_mem_data)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return 32'h90 + {24'h0, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response monitor, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (!i_rst && o_rsp_valid) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check("rsp_data", 64'(o_rsp_data), 64'(sb_e.data));
        check("rsp_hit", 64'(o_rsp_hit), 64'(sb_e.hit));
      end
    end
  end

  task automatic push_exp(input logic [7:0] addr, input logic hit);
    exp_t e;
    e.data = mem_word(addr);
    e.hit  = hit;
    sb_q.push_back(e);
  endtask

  task automatic wait_sb_empty(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 16) begin
      @(posedge i_clk); #1;
      n++;
    end
    check(tag, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic apply_reset(input bit check_state);
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    if (check_state) begin
      check("rst_ready", 64'(o_req_ready), 64'd1);
      check("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
      check("rst_rsp_hit", 64'(o_rsp_hit), 64'd0);
      check("rst_rsp_data", 64'(o_rsp_data), 64'd0);
      check("rst_mem_req", 64'(o_mem_req), 64'd0);
      check("rst_mem_addr", 64'(o_mem_addr), 64'd0);
    end
  endtask

  task automatic do_hit(input logic [7:0] addr);
    push_exp(addr, 1'b1);
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    wait_sb_empty("hit_rsp_wait");
  endtask

  // Miss: optional ack stall with stray fill pulses, optional flush on the first fill word.
  task automatic do_miss(input logic [7:0] addr, input int stall, input bit flush_fill);
    logic [7:0] line;
    int n = 0;
    line = addr & 8'hFE;
    push_exp(addr, 1'b0);
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    while (!o_mem_req && n < 8) begin
      @(posedge i_clk); #1;
      n++;
    end
    check("mem_req", 64'(o_mem_req), 64'd1);
    if (!o_mem_req) return;
    check("mem_addr", 64'(o_mem_addr), 64'(line));
    for (int s = 0; s < stall; s++) begin
      i_mem_valid = (s % 2 == 0);
      i_mem_data  = 32'hDEAD_0000 + s;
      @(posedge i_clk); #1;
      i_mem_valid = 1'b0;
      check("stall_mem_req", 64'(o_mem_req), 64'd1);
      check("stall_mem_addr", 64'(o_mem_addr), 64'(line));
    end
    i_mem_ack = 1'b1;
    @(posedge i_clk); #1;
    i_mem_ack = 1'b0;
    check("mem_req_drop", 64'(o_mem_req), 64'd0);
    for (int k = 0; k < 2; k++) begin
      i_mem_valid = 1'b1;
      i_mem_data  = mem_word(line + 8'(k));
      i_flush     = flush_fill && (k == 0);
      @(posedge i_clk); #1;
      i_flush     = 1'b0;
      i_mem_valid = 1'b0;
    end
    wait_sb_empty("miss_rsp_wait");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    i_clk        = 1'b0;
    i_rst        = 1'b1;
    i_flush      = 1'b0;
    i_req_valid  = 1'b0;
    i_req_addr   = '0;
    i_mem_ack    = 1'b0;
    i_mem_valid  = 1'b0;
    i_mem_data   = '0;
    apply_reset(1'b1);

    // Cold miss then hit on the other word of the same line.
    do_miss(8'h11, 0, 1'b0);
    do_hit(8'h10);

    // Conflict in set 0 with round-robin replacement.
    apply_reset(1'b0);
    do_miss(8'h00, 0, 1'b0);   // way0, rr -> 1
    do_miss(8'h08, 0, 1'b0);   // way1 (invalid), rr -> 0
    do_miss(8'h10, 0, 1'b0);   // evicts way0 (0x00), rr -> 1
    do_hit(8'h08);
    do_miss(8'h00, 0, 1'b0);   // evicts way1 (0x08), rr -> 0
    do_hit(8'h10);

    // Back-to-back hits, one per cycle.
    push_exp(8'h10, 1'b1);
    push_exp(8'h11, 1'b1);
    push_exp(8'h10, 1'b1);
    i_req_valid = 1'b1;
    i_req_addr  = 8'h10; #1 check("stream_ready0", 64'(o_req_ready), 64'd1);
    @(posedge i_clk); #1;
    i_req_addr  = 8'h11; check("stream_ready1", 64'(o_req_ready), 64'd1);
    @(posedge i_clk); #1;
    i_req_addr  = 8'h10; check("stream_ready2", 64'(o_req_ready), 64'd1);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    wait_sb_empty("stream_rsp_wait");

    // Ack stall with stray fill pulses; line must still fill correctly.
    do_miss(8'h02, 5, 1'b0);
    do_hit(8'h03);
    do_hit(8'h02);

    // Flush with a pending request: refused, then prior hit misses.
    i_flush     = 1'b1;
    i_req_valid = 1'b1;
    i_req_addr  = 8'h10;
    #1 check("flush_ready", 64'(o_req_ready), 64'd0);
    @(posedge i_clk); #1;
    i_flush     = 1'b0;
    i_req_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    do_miss(8'h10, 0, 1'b0);
    do_hit(8'h11);

    // Flush during fill: response returned, line left invalid.
    do_miss(8'h04, 0, 1'b1);
    do_miss(8'h04, 0, 1'b0);
    do_hit(8'h05);

    // Reset in the middle of a fill.
    i_req_valid = 1'b1;
    i_req_addr  = 8'h10;      // invalid since the flush
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    check("rmf_mem_req", 64'(o_mem_req), 64'd1);
    i_mem_ack = 1'b1;
    @(posedge i_clk); #1;
    i_mem_ack   = 1'b0;
    i_mem_valid = 1'b1;
    i_mem_data  = mem_word(8'h10);
    @(posedge i_clk); #1;
    i_mem_valid = 1'b0;
    i_rst       = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    check("rmf_mem_req_drop", 64'(o_mem_req), 64'd0);
    check("rmf_ready", 64'(o_req_ready), 64'd1);
    i_mem_valid = 1'b1;
    i_mem_data  = 32'hBAD0_BAD0;
    repeat (2) @(posedge i_clk);
    #1 i_mem_valid = 1'b0;
    @(posedge i_clk); #1;
    do_miss(8'h04, 0, 1'b0);  // valid before the reset
    do_hit(8'h05);
    do_miss(8'h10, 0, 1'b0);
    do_hit(8'h11);

    repeat (3) @(posedge i_clk);
    #1 check("sb_empty_final", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
